game_match_ctrl: RTL

Match controller for the multimode counter game. It sequences the shared `full_game` core across a best-of-N match. It loads the starting value, arbitrates moves from two players with round-robin priority, and injects a default move when both players stall. It also scores each round from `gameover`/`who` and declares the match winner.

---
 rtl/game_match_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/game_match_ctrl.sv
// Match controller for the multimode counter game: sequences the full_game core
// through a best-of-N match, arbitrating player moves and scoring each round.
module game_match_ctrl #(
    parameter int N             = 4,
    parameter int ROUNDS_TO_WIN = 3,
    parameter int MOVE_TIMEOUT  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] seed,
    input  logic         p0_req,
    input  logic         p1_req,
    input  logic [1:0]   p0_move,
    input  logic [1:0]   p1_move,
    input  logic         gameover,
    input  logic [1:0]   who,
    output logic         init,
    output logic [N-1:0] initial_val,
    output logic [1:0]   control,
    output logic         step,
    output logic [1:0]   grant,
    output logic         timeout,
    output logic [2:0]   score0,
    output logic [2:0]   score1,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         match_done,
    output logic         match_winner
);

    typedef enum logic [2:0] {IDLE, LOAD, ARB, STEP, SCORE, DONE} state_t;

    localparam logic [2:0] WIN       = 3'(ROUNDS_TO_WIN);
    localparam logic [7:0] IDLE_LAST = 8'(MOVE_TIMEOUT - 1);

    state_t       state, state_next;
    logic [N-1:0] seed_q, seed_next, initial_val_next;
    logic [7:0]   idle_cnt, idle_next;
    logic         moved, moved_next;
    logic         last_grant, last_next;
    logic [2:0]   score0_next, score1_next;
    logic [3:0]   round_next;
    logic         winner_next, init_next, step_next, timeout_next;
    logic [1:0]   control_next, grant_next;

    always_comb begin
        state_next   = state;
        seed_next    = seed_q;
        idle_next    = idle_cnt;
        moved_next   = moved;
        last_next    = last_grant;
        score0_next  = score0;
        score1_next  = score1;
        round_next   = round_idx;
        winner_next  = match_winner;
        init_next    = 1'b0;
        step_next    = 1'b0;
        timeout_next = 1'b0;
        control_next = 2'b00;
        grant_next   = 2'b00;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = LOAD;
                    seed_next   = seed;
                    score0_next = 3'd0;
                    score1_next = 3'd0;
                    round_next  = 4'd0;
                    winner_next = 1'b0;
                end
            end
            LOAD: begin
                state_next = ARB;
                moved_next = 1'b0;
                idle_next  = 8'd0;
            end
            ARB: begin
                // A finished round is only believed once this round has seen a move.
                if (gameover && who != 2'd0 && moved) begin
                    state_next = SCORE;
                    if (who == 2'd2)
                        score0_next = score0 + 3'd1;
                    else if (who == 2'd1)
                        score1_next = score1 + 3'd1;
                end else if (p0_req && (!p1_req || last_grant)) begin
                    state_next   = STEP;
                    step_next    = 1'b1;
                    grant_next   = 2'b01;
                    control_next = p0_move;
                    last_next    = 1'b0;
                end else if (p1_req) begin
                    state_next   = STEP;
                    step_next    = 1'b1;
                    grant_next   = 2'b10;
                    control_next = p1_move;
                    last_next    = 1'b1;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_next   = STEP;
                    step_next    = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    idle_next = idle_cnt + 8'd1;
                end
            end
            STEP: begin
                state_next = ARB;
                moved_next = 1'b1;
                idle_next  = 8'd0;
            end
            SCORE: begin
                if (score0 == WIN || score1 == WIN) begin
                    state_next  = DONE;
                    winner_next = (score1 == WIN);
                end else begin
                    state_next = LOAD;
                    round_next = (round_idx == 4'd15) ? 4'd15 : round_idx + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        initial_val_next = initial_val;
        if (state_next == LOAD && state != LOAD) begin
            init_next        = 1'b1;
            initial_val_next = seed_next + N'(round_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            seed_q       <= '0;
            idle_cnt     <= 8'd0;
            moved        <= 1'b0;
            last_grant   <= 1'b1;
            init         <= 1'b0;
            initial_val  <= '0;
            control      <= 2'b00;
            step         <= 1'b0;
            grant        <= 2'b00;
            timeout      <= 1'b0;
            score0       <= 3'd0;
            score1       <= 3'd0;
            round_idx    <= 4'd0;
            busy         <= 1'b0;
            match_done   <= 1'b0;
            match_winner <= 1'b0;
        end else begin
            state        <= state_next;
            seed_q       <= seed_next;
            idle_cnt     <= idle_next;
            moved        <= moved_next;
            last_grant   <= last_next;
            init         <= init_next;
            initial_val  <= initial_val_next;
            control      <= control_next;
            step         <= step_next;
            grant        <= grant_next;
            timeout      <= timeout_next;
            score0       <= score0_next;
            score1       <= score1_next;
            round_idx    <= round_next;
            busy         <= (state_next != IDLE) && (state_next != DONE);
            match_done   <= (state_next == DONE);
            match_winner <= winner_next;
        end
    end

endmodule
